// File: rtl/ama_riscv_bp_bimodal_if.sv
// ama_riscv_bp_bimodal_if: predictor bus between front-end/execute and the bimodal predictor (branch outcome 1 = taken, 0 = not taken)
interface ama_riscv_bp_bimodal_if;
  logic [31:0] pc_dec;
  logic branch_in_dec;
  logic [31:0] pc_exe;
  logic branch_in_exe;
  logic branch_resolution;
  logic exe_stall;
  logic mispredict;
  logic bp_pred;
  logic [31:0] cnt_branches;
  logic [31:0] cnt_mispred;
  modport master (
    output pc_dec, branch_in_dec, pc_exe, branch_in_exe, branch_resolution, exe_stall, mispredict,
    input bp_pred, cnt_branches, cnt_mispred
  );
  modport slave (
    input pc_dec, branch_in_dec, pc_exe, branch_in_exe, branch_resolution, exe_stall, mispredict,
    output bp_pred, cnt_branches, cnt_mispred
  );
endinterface

// File: rtl/ama_riscv_bp_bimodal.sv
// ama_riscv_bp_bimodal: PC-indexed table of 2-bit saturating counters with same-cycle bypass and perf counters
module ama_riscv_bp_bimodal #(
  parameter int PC_BITS = 7,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic clk,
  input logic rst,
  ama_riscv_bp_bimodal_if.slave bp
);
  localparam int N = 2**PC_BITS;
  logic [1:0] r_cnt [N];
  logic [31:0] r_cnt_branches;
  logic [31:0] r_cnt_mispred;
  logic [PC_BITS-1:0] w_idx_dec;
  logic [PC_BITS-1:0] w_idx_exe;
  logic w_upd;
  logic [1:0] w_cur;
  logic [1:0] w_next;
  logic [1:0] w_dec_cnt;
  logic w_unused;
  assign w_idx_dec = bp.pc_dec[PC_BITS+1:2];
  assign w_idx_exe = bp.pc_exe[PC_BITS+1:2];
  assign w_upd = bp.branch_in_exe && !bp.exe_stall && !rst;
  assign w_cur = r_cnt[w_idx_exe];
  assign w_next = bp.branch_resolution ? ((w_cur == 2'b11) ? w_cur : w_cur + 2'd1)
                                       : ((w_cur == 2'b00) ? w_cur : w_cur - 2'd1);
  // decode sees the counter as it will be after this cycle's training
  assign w_dec_cnt = (w_upd && w_idx_dec == w_idx_exe) ? w_next : r_cnt[w_idx_dec];
  assign bp.bp_pred = !rst && bp.branch_in_dec && w_dec_cnt[1];
  assign bp.cnt_branches = r_cnt_branches;
  assign bp.cnt_mispred = r_cnt_mispred;
  assign w_unused = ^{bp.pc_dec[31:PC_BITS+2], bp.pc_dec[1:0], bp.pc_exe[31:PC_BITS+2], bp.pc_exe[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '{default: CNT_INIT};
      r_cnt_branches <= '0;
      r_cnt_mispred <= '0;
    end else begin
      if (w_upd) r_cnt[w_idx_exe] <= w_next;
      if (w_upd) r_cnt_branches <= r_cnt_branches + 32'd1;
      if (bp.mispredict && !bp.exe_stall) r_cnt_mispred <= r_cnt_mispred + 32'd1;
    end
  end
  a_mispred_needs_branch: assert property (@(posedge clk) disable iff (rst) bp.mispredict |-> bp.branch_in_exe);
endmodule

// File: tb/tb_ama_riscv_bp_bimodal.sv
// tb_ama_riscv_bp_bimodal: directed plus random stimulus checked against a table/counter reference model
module tb_ama_riscv_bp_bimodal;
  logic clk = 0;
  logic rst = 1;
  int n_assert = 0;
  int n_fail = 0;
  int mdl [128];
  int unsigned m_br = 0;
  int unsigned m_mis = 0;
  ama_riscv_bp_bimodal_if bp_if();
  ama_riscv_bp_bimodal dut (.clk(clk), .rst(rst), .bp(bp_if.slave));
  always #5 clk = ~clk;

  function automatic int nxt(int c, bit t);
    return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction

  task automatic cycle(bit r, logic [31:0] pcd, bit bd, logic [31:0] pce, bit be, bit res, bit st, bit mp);
    int id, ie, c;
    bit upd, exp;
    rst = r;
    bp_if.pc_dec = pcd; bp_if.branch_in_dec = bd;
    bp_if.pc_exe = pce; bp_if.branch_in_exe = be;
    bp_if.branch_resolution = res; bp_if.exe_stall = st; bp_if.mispredict = mp;
    #1;
    id = (pcd / 4) % 128;
    ie = (pce / 4) % 128;
    upd = be && !st && !r;
    c = (upd && id == ie) ? nxt(mdl[ie], res) : mdl[id];
    exp = !r && bd && c >= 2;
    n_assert++;
    assert (bp_if.bp_pred === exp) else begin
      n_fail++;
      $error("FAIL pred pc_dec=%h got=%b exp=%b", pcd, bp_if.bp_pred, exp);
    end
    @(posedge clk);
    if (r) begin
      foreach (mdl[i]) mdl[i] = 1;
      m_br = 0; m_mis = 0;
    end else begin
      if (upd) begin mdl[ie] = nxt(mdl[ie], res); m_br++; end
      if (mp && !st) m_mis++;
    end
    @(negedge clk);
    n_assert++;
    assert (bp_if.cnt_branches === m_br) else begin
      n_fail++;
      $error("FAIL cnt_branches got=%0d exp=%0d", bp_if.cnt_branches, m_br);
    end
    n_assert++;
    assert (bp_if.cnt_mispred === m_mis) else begin
      n_fail++;
      $error("FAIL cnt_mispred got=%h exp=%h", bp_if.cnt_mispred, m_mis);
    end
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = 1;
    @(negedge clk);
    cycle(1, 32'h100, 1, 0, 0, 0, 0, 0);
    n_assert++;
    assert (dut.r_cnt[7'h40] === 2'b01) else begin
      n_fail++;
      $error("FAIL entry40 got=%b exp=01", dut.r_cnt[7'h40]);
    end
    cycle(0, 32'h100, 1, 0, 0, 0, 0, 0);
    cycle(0, 32'h100, 0, 32'h100, 1, 1, 0, 0);
    cycle(0, 32'h100, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h100, 1, 32'h100, 1, 1, 0, 0);
    n_assert++;
    assert (dut.r_cnt[7'h40] === 2'b11) else begin
      n_fail++;
      $error("FAIL sat_hi got=%b exp=11", dut.r_cnt[7'h40]);
    end
    for (int i = 0; i < 2; i++) cycle(0, 32'h100, 1, 32'h100, 1, 0, 0, 1);
    cycle(0, 32'h100, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h100, 1, 32'h100, 1, 1, 1, 0);
    cycle(0, 32'h100, 1, 32'h100, 1, 1, 0, 0);
    n_assert++;
    assert (dut.r_cnt[7'h40] === 2'b10) else begin
      n_fail++;
      $error("FAIL stall_once got=%b exp=10", dut.r_cnt[7'h40]);
    end
    cycle(0, 32'h200, 1, 32'h200, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 32'h004, 1, 1, 0, 0);
    cycle(0, 32'h204, 1, 0, 0, 0, 0, 0);
    force dut.r_cnt_mispred = 32'hFFFF_FFFF;
    #1 release dut.r_cnt_mispred;
    m_mis = 32'hFFFF_FFFF;
    cycle(0, 32'h0, 0, 32'h300, 1, 0, 0, 1);
    cycle(0, 32'h100, 1, 32'h100, 1, 1, 0, 0);
    cycle(1, 32'h100, 1, 32'h100, 1, 1, 0, 1);
    n_assert++;
    assert (dut.r_cnt[7'h40] === 2'b01) else begin
      n_fail++;
      $error("FAIL rst_dom got=%b exp=01", dut.r_cnt[7'h40]);
    end
    cycle(0, 32'h100, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pd, pe;
      bit be;
      pd = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 9);
      pe = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 9);
      be = 1'($urandom_range(0, 1));
      cycle($urandom_range(0, 49) == 0, pd, 1'($urandom_range(0, 1)), pe, be,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, be && $urandom_range(0, 2) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
